mips_mc_ctrl: RTL and testbench

//  Multi-cycle control unit for the MIPS core: the successor to the single-cycle controller.

---
 rtl/mips_pkg.sv | 92 +++++++++
 rtl/mips_mc_decode.sv | 88 ++++++++
 rtl/mips_mc_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller. This file holds the
// opcode/funct values, the ALU and mux select codes, the FSM state enum and the
// instruction classes that the decoder produces.
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // ALU function encodings, shared with the core's ALU
    localparam int         ALU_OP_W_DEF = 3;
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;

    // Next-PC source
    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_RS     = 2'b11;

    // Immediate extender mode
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // Register-file destination select
    localparam logic [1:0] GPR_RT = 2'b00;
    localparam logic [1:0] GPR_RD = 2'b01;
    localparam logic [1:0] GPR_RA = 2'b10;
    localparam logic [1:0] GPR_OF = 2'b11;

    // Write-back data select
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_DM  = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    // Controller states; the encoding is visible on the debug state port
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_JUMP   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    // Instruction classes: each class follows one fixed path through the FSM
    typedef enum logic [3:0] {
        CLS_ALU_R,   // addu/subu: EXE -> WB into rd
        CLS_ALU_I,   // ori/lui:   EXE -> WB into rt
        CLS_ADDI,    // addi:      EXE -> WB into rt, or $30 on overflow
        CLS_LOAD,    // lw/lb
        CLS_STORE,   // sw/sb
        CLS_BEQ,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_ILL
    } cls_t;

    // Decoder result: class plus the controls the EXE state drives
    typedef struct packed {
        cls_t       cls;
        logic [2:0] alu_op;
        logic       bsel;
        logic [1:0] ext_op;
        logic       byte_acc;
    } dec_t;

    // True for the classes that pass through the MEM state
    function automatic logic is_mem_cls(input cls_t cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction decoder for the multi-cycle controller. It maps
// opcode/funct to an instruction class and the ALU/extender controls that the
// EXE (or BRANCH) state applies. Unknown encodings decode to CLS_ILL.
module mips_mc_decode
    import mips_pkg::*;
#(
    parameter bit HAS_BYTE = 1'b1
) (
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output dec_t       o_dec
);

    // Classify the instruction held in IR
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_dec          = '0;
        o_dec.cls      = CLS_ILL;
        o_dec.alu_op   = ALU_ADD;
        o_dec.bsel     = 1'b0;
        o_dec.ext_op   = EXT_ZERO;
        o_dec.byte_acc = 1'b0;

        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: o_dec.cls = CLS_ALU_R;
                    FN_SUBU: begin
                        o_dec.cls    = CLS_ALU_R;
                        o_dec.alu_op = ALU_SUB;
                    end
                    FN_JR:   o_dec.cls = CLS_JR;
                    default: o_dec.cls = CLS_ILL;
                endcase
            end
            OP_ADDI: begin
                o_dec.cls    = CLS_ADDI;
                o_dec.bsel   = 1'b1;
                o_dec.ext_op = EXT_SIGN;
            end
            OP_ORI: begin
                o_dec.cls    = CLS_ALU_I;
                o_dec.alu_op = ALU_OR;
                o_dec.bsel   = 1'b1;
            end
            OP_LUI: begin
                // rs is $0 for lui, so ADD passes the shifted immediate through
                o_dec.cls    = CLS_ALU_I;
                o_dec.bsel   = 1'b1;
                o_dec.ext_op = EXT_LUI;
            end
            OP_LW: begin
                o_dec.cls    = CLS_LOAD;
                o_dec.bsel   = 1'b1;
                o_dec.ext_op = EXT_SIGN;
            end
            OP_SW: begin
                o_dec.cls    = CLS_STORE;
                o_dec.bsel   = 1'b1;
                o_dec.ext_op = EXT_SIGN;
            end
            OP_LB: begin
                if (HAS_BYTE) begin
                    o_dec.cls      = CLS_LOAD;
                    o_dec.bsel     = 1'b1;
                    o_dec.ext_op   = EXT_SIGN;
                    o_dec.byte_acc = 1'b1;
                end
            end
            OP_SB: begin
                if (HAS_BYTE) begin
                    o_dec.cls      = CLS_STORE;
                    o_dec.bsel     = 1'b1;
                    o_dec.ext_op   = EXT_SIGN;
                    o_dec.byte_acc = 1'b1;
                end
            end
            OP_BEQ: begin
                o_dec.cls    = CLS_BEQ;
                o_dec.alu_op = ALU_SUB;
            end
            OP_J:    o_dec.cls = CLS_J;
            OP_JAL:  o_dec.cls = CLS_JAL;
            default: o_dec.cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit. Each instruction walks FETCH -> DECODE and then
// one of the EXE/MEM/WB, BRANCH or JUMP paths back to FETCH. All datapath
// controls are registered: the value for a state is computed on the edge that
// enters it. The data-memory wait is bounded by MEM_TIMEOUT; an expired wait or
// an illegal instruction parks the controller in TRAP until reset.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int ALU_OP_W    = ALU_OP_W_DEF,
    parameter int MEM_TIMEOUT = 255,
    parameter bit HAS_BYTE    = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [5:0]          i_opcode,
    input  logic [5:0]          i_funct,
    input  logic                i_zero,
    input  logic                i_of,
    input  logic                i_mem_ready,
    output logic                o_ir_wr,
    output logic                o_pc_wr,
    output logic [1:0]          o_npc_sel,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic                o_bsel,
    output logic [1:0]          o_ext_op,
    output logic [1:0]          o_gpr_sel,
    output logic [1:0]          o_wd_sel,
    output logic                o_gpr_wr,
    output logic                o_mem_req,
    output logic                o_dm_wr,
    output logic                o_lb,
    output logic                o_sb,
    output logic                o_trap,
    output logic [2:0]          o_state
);

    // Counter value on the last waiting cycle that is still allowed
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    dec_t                w_dec;

    state_t              r_state;
    cls_t                r_cls;
    logic                r_byte;
    logic [7:0]          r_wait_cnt;

    logic                r_ir_wr;
    logic                r_pc_wr;
    logic [1:0]          r_npc_sel;
    logic [ALU_OP_W-1:0] r_alu_op;
    logic                r_bsel;
    logic [1:0]          r_ext_op;
    logic [1:0]          r_gpr_sel;
    logic [1:0]          r_wd_sel;
    logic                r_gpr_wr;
    logic                r_mem_req;
    logic                r_dm_wr;
    logic                r_lb;
    logic                r_sb;
    logic                r_trap;

    mips_mc_decode #(
        .HAS_BYTE (HAS_BYTE)
    ) u_decode (
        .i_opcode (i_opcode),
        .i_funct  (i_funct),
        .o_dec    (w_dec)
    );

    // Controller FSM: state, wait counter and every registered output
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_FETCH;
            r_cls      <= CLS_ILL;
            r_byte     <= 1'b0;
            r_wait_cnt <= '0;
            r_ir_wr    <= 1'b0;
            r_pc_wr    <= 1'b0;
            r_npc_sel  <= NPC_PC4;
            r_alu_op   <= '0;
            r_bsel     <= 1'b0;
            r_ext_op   <= EXT_ZERO;
            r_gpr_sel  <= GPR_RT;
            r_wd_sel   <= WD_ALU;
            r_gpr_wr   <= 1'b0;
            r_mem_req  <= 1'b0;
            r_dm_wr    <= 1'b0;
            r_lb       <= 1'b0;
            r_sb       <= 1'b0;
            r_trap     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the defaults below are
            // overridden by the later assignments for the state being entered.
            r_ir_wr   <= 1'b0;
            r_pc_wr   <= 1'b0;
            r_npc_sel <= NPC_PC4;
            r_alu_op  <= '0;
            r_bsel    <= 1'b0;
            r_ext_op  <= EXT_ZERO;
            r_gpr_sel <= GPR_RT;
            r_wd_sel  <= WD_ALU;
            r_gpr_wr  <= 1'b0;
            r_mem_req <= 1'b0;
            r_dm_wr   <= 1'b0;
            r_lb      <= 1'b0;
            r_sb      <= 1'b0;

            case (r_state)
                S_FETCH: begin
                    // The first cycle after reset sits in FETCH with no strobes;
                    // it only arms the real fetch cycle that follows.
                    if (r_ir_wr) begin
                        r_state <= S_DECODE;
                    end else begin
                        r_ir_wr <= 1'b1;
                        r_pc_wr <= 1'b1;
                    end
                end

                S_DECODE: begin
                    r_cls  <= w_dec.cls;
                    r_byte <= w_dec.byte_acc;
                    case (w_dec.cls)
                        CLS_ALU_R, CLS_ALU_I, CLS_ADDI, CLS_LOAD, CLS_STORE: begin
                            r_state  <= S_EXE;
                            r_alu_op <= ALU_OP_W'(w_dec.alu_op);
                            r_bsel   <= w_dec.bsel;
                            r_ext_op <= w_dec.ext_op;
                        end
                        CLS_BEQ: begin
                            r_state   <= S_BRANCH;
                            r_alu_op  <= ALU_OP_W'(w_dec.alu_op);
                            r_bsel    <= 1'b0;
                            r_npc_sel <= NPC_BRANCH;
                        end
                        CLS_J: begin
                            r_state   <= S_JUMP;
                            r_pc_wr   <= 1'b1;
                            r_npc_sel <= NPC_JUMP;
                        end
                        CLS_JAL: begin
                            r_state   <= S_JUMP;
                            r_pc_wr   <= 1'b1;
                            r_npc_sel <= NPC_JUMP;
                            r_gpr_wr  <= 1'b1;
                            r_gpr_sel <= GPR_RA;
                            r_wd_sel  <= WD_PC4;
                        end
                        CLS_JR: begin
                            r_state   <= S_JUMP;
                            r_pc_wr   <= 1'b1;
                            r_npc_sel <= NPC_RS;
                        end
                        default: begin
                            r_state <= S_TRAP;
                            r_trap  <= 1'b1;
                        end
                    endcase
                end

                S_EXE: begin
                    if (is_mem_cls(r_cls)) begin
                        r_state    <= S_MEM;
                        r_wait_cnt <= '0;
                        r_mem_req  <= 1'b1;
                        r_dm_wr    <= (r_cls == CLS_STORE);
                        r_lb       <= (r_cls == CLS_LOAD) && r_byte;
                        r_sb       <= (r_cls == CLS_STORE) && r_byte;
                    end else begin
                        r_state  <= S_WB;
                        r_gpr_wr <= 1'b1;
                        r_wd_sel <= WD_ALU;
                        if (r_cls == CLS_ALU_R) begin
                            r_gpr_sel <= GPR_RD;
                        end else if ((r_cls == CLS_ADDI) && i_of) begin
                            // Overflowing addi writes $30 instead of rt
                            r_gpr_sel <= GPR_OF;
                        end else begin
                            r_gpr_sel <= GPR_RT;
                        end
                    end
                end

                S_MEM: begin
                    if (i_mem_ready) begin
                        if (r_cls == CLS_LOAD) begin
                            r_state  <= S_WB;
                            r_gpr_wr <= 1'b1;
                            r_gpr_sel <= GPR_RT;
                            r_wd_sel <= WD_DM;
                        end else begin
                            r_state <= S_FETCH;
                            r_ir_wr <= 1'b1;
                            r_pc_wr <= 1'b1;
                        end
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        // Wait budget spent: request drops as TRAP is entered
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                        r_mem_req  <= 1'b1;
                        r_dm_wr    <= r_dm_wr;
                        r_lb       <= r_lb;
                        r_sb       <= r_sb;
                    end
                end

                S_WB, S_BRANCH, S_JUMP: begin
                    r_state <= S_FETCH;
                    r_ir_wr <= 1'b1;
                    r_pc_wr <= 1'b1;
                end

                S_TRAP: begin
                    r_state <= S_TRAP;
                end

                default: begin
                    r_state <= S_TRAP;
                    r_trap  <= 1'b1;
                end
            endcase
        end
    end

    // Output mapping. The branch compare is computed by the ALU during BRANCH
    // itself, so its zero flag qualifies pc_wr within that cycle.
    assign o_ir_wr   = r_ir_wr;
    assign o_pc_wr   = r_pc_wr | ((r_state == S_BRANCH) & i_zero);
    assign o_npc_sel = r_npc_sel;
    assign o_alu_op  = r_alu_op;
    assign o_bsel    = r_bsel;
    assign o_ext_op  = r_ext_op;
    assign o_gpr_sel = r_gpr_sel;
    assign o_wd_sel  = r_wd_sel;
    assign o_gpr_wr  = r_gpr_wr;
    assign o_mem_req = r_mem_req;
    assign o_dm_wr   = r_dm_wr;
    assign o_lb      = r_lb;
    assign o_sb      = r_sb;
    assign o_trap    = r_trap;
    assign o_state   = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl. A behavioural model turns each
// instruction into the expected per-cycle output trace (from the instruction
// class, the memory wait count and the zero/of flags) and the bench compares
// every cycle of the DUT against it. A second instance without byte support
// checks that lb/sb trap there.
module tb_mips_mc_ctrl;
    import mips_pkg::*;

    localparam int TO = 4;

    typedef struct packed {
        logic       ir_wr;
        logic       pc_wr;
        logic [1:0] npc_sel;
        logic [2:0] alu_op;
        logic       bsel;
        logic [1:0] ext_op;
        logic [1:0] gpr_sel;
        logic [1:0] wd_sel;
        logic       gpr_wr;
        logic       mem_req;
        logic       dm_wr;
        logic       lb;
        logic       sb;
        logic       trap;
        logic [2:0] state;
    } obs_t;

    typedef enum logic [3:0] {K_R, K_I, K_ADDI, K_LD, K_ST, K_BEQ, K_J, K_JAL, K_JR, K_ILL} kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [2:0] alu;
        logic       bsel;
        logic [1:0] ext;
        logic       byt;
    } info_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       of = 1'b0;
    logic       mem_ready = 1'b0;

    logic       o_ir_wr, o_pc_wr, o_bsel, o_gpr_wr, o_mem_req, o_dm_wr, o_lb, o_sb, o_trap;
    logic [1:0] o_npc_sel, o_ext_op, o_gpr_sel, o_wd_sel;
    logic [2:0] o_alu_op, o_state;

    logic       b_ir_wr, b_pc_wr, b_bsel, b_gpr_wr, b_mem_req, b_dm_wr, b_lb, b_sb, b_trap;
    logic [1:0] b_npc_sel, b_ext_op, b_gpr_sel, b_wd_sel;
    logic [2:0] b_alu_op, b_state;

    obs_t w_obs;
    assign w_obs = {o_ir_wr, o_pc_wr, o_npc_sel, o_alu_op, o_bsel, o_ext_op, o_gpr_sel,
                    o_wd_sel, o_gpr_wr, o_mem_req, o_dm_wr, o_lb, o_sb, o_trap, o_state};

    mips_mc_ctrl #(.ALU_OP_W(3), .MEM_TIMEOUT(TO), .HAS_BYTE(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_funct(funct), .i_zero(zero),
        .i_of(of), .i_mem_ready(mem_ready), .o_ir_wr(o_ir_wr), .o_pc_wr(o_pc_wr),
        .o_npc_sel(o_npc_sel), .o_alu_op(o_alu_op), .o_bsel(o_bsel), .o_ext_op(o_ext_op),
        .o_gpr_sel(o_gpr_sel), .o_wd_sel(o_wd_sel), .o_gpr_wr(o_gpr_wr), .o_mem_req(o_mem_req),
        .o_dm_wr(o_dm_wr), .o_lb(o_lb), .o_sb(o_sb), .o_trap(o_trap), .o_state(o_state)
    );

    mips_mc_ctrl #(.ALU_OP_W(3), .MEM_TIMEOUT(255), .HAS_BYTE(1'b0)) dut_nobyte (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_funct(funct), .i_zero(zero),
        .i_of(of), .i_mem_ready(mem_ready), .o_ir_wr(b_ir_wr), .o_pc_wr(b_pc_wr),
        .o_npc_sel(b_npc_sel), .o_alu_op(b_alu_op), .o_bsel(b_bsel), .o_ext_op(b_ext_op),
        .o_gpr_sel(b_gpr_sel), .o_wd_sel(b_wd_sel), .o_gpr_wr(b_gpr_wr), .o_mem_req(b_mem_req),
        .o_dm_wr(b_dm_wr), .o_lb(b_lb), .o_sb(b_sb), .o_trap(b_trap), .o_state(b_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    obs_t exp_q[$];
    bit   rdy_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    // Instruction table: class and EXE-stage controls for each encoding
    function automatic info_t classify(input logic [5:0] op, input logic [5:0] fn, input bit has_byte);
        info_t r;
        r = '{kind: K_ILL, alu: ALU_ADD, bsel: 1'b0, ext: EXT_ZERO, byt: 1'b0};
        case (op)
            6'h00: begin
                if (fn == 6'h21)      r.kind = K_R;
                else if (fn == 6'h23) begin r.kind = K_R; r.alu = ALU_SUB; end
                else if (fn == 6'h08) r.kind = K_JR;
            end
            6'h08: begin r.kind = K_ADDI; r.bsel = 1'b1; r.ext = EXT_SIGN; end
            6'h0D: begin r.kind = K_I; r.alu = ALU_OR; r.bsel = 1'b1; end
            6'h0F: begin r.kind = K_I; r.bsel = 1'b1; r.ext = EXT_LUI; end
            6'h23: begin r.kind = K_LD; r.bsel = 1'b1; r.ext = EXT_SIGN; end
            6'h2B: begin r.kind = K_ST; r.bsel = 1'b1; r.ext = EXT_SIGN; end
            6'h20: if (has_byte) begin r.kind = K_LD; r.bsel = 1'b1; r.ext = EXT_SIGN; r.byt = 1'b1; end
            6'h28: if (has_byte) begin r.kind = K_ST; r.bsel = 1'b1; r.ext = EXT_SIGN; r.byt = 1'b1; end
            6'h04: begin r.kind = K_BEQ; r.alu = ALU_SUB; end
            6'h02: r.kind = K_J;
            6'h03: r.kind = K_JAL;
            default: ;
        endcase
        return r;
    endfunction

    function automatic obs_t blank(input state_t st);
        obs_t e;
        e = '0;
        e.state = st;
        return e;
    endfunction

    function automatic bit noise();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected per-cycle trace of one instruction, starting with its FETCH cycle
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int waits,
                         input logic z, input logic ov);
        info_t inf;
        obs_t  e;
        inf = classify(op, fn, 1'b1);
        exp_q.delete();
        rdy_q.delete();

        e = blank(S_FETCH); e.ir_wr = 1'b1; e.pc_wr = 1'b1;
        exp_q.push_back(e); rdy_q.push_back(noise());
        exp_q.push_back(blank(S_DECODE)); rdy_q.push_back(noise());

        if (inf.kind inside {K_R, K_I, K_ADDI, K_LD, K_ST}) begin
            e = blank(S_EXE); e.alu_op = inf.alu; e.bsel = inf.bsel; e.ext_op = inf.ext;
            exp_q.push_back(e); rdy_q.push_back(noise());
        end

        case (inf.kind)
            K_R, K_I, K_ADDI: begin
                e = blank(S_WB); e.gpr_wr = 1'b1; e.wd_sel = WD_ALU;
                if (inf.kind == K_R)           e.gpr_sel = GPR_RD;
                else if (inf.kind == K_ADDI && ov) e.gpr_sel = GPR_OF;
                else                           e.gpr_sel = GPR_RT;
                exp_q.push_back(e); rdy_q.push_back(noise());
            end
            K_LD, K_ST: begin
                for (int j = 0; j < TO; j++) begin
                    e = blank(S_MEM); e.mem_req = 1'b1;
                    e.dm_wr = (inf.kind == K_ST);
                    e.lb = (inf.kind == K_LD) && inf.byt;
                    e.sb = (inf.kind == K_ST) && inf.byt;
                    exp_q.push_back(e); rdy_q.push_back(j == waits);
                    if (j == waits) break;
                end
                if (waits >= TO) begin
                    for (int j = 0; j < 3; j++) begin
                        e = blank(S_TRAP); e.trap = 1'b1;
                        exp_q.push_back(e); rdy_q.push_back(noise());
                    end
                end else if (inf.kind == K_LD) begin
                    e = blank(S_WB); e.gpr_wr = 1'b1; e.wd_sel = WD_DM; e.gpr_sel = GPR_RT;
                    exp_q.push_back(e); rdy_q.push_back(noise());
                end
            end
            K_BEQ: begin
                e = blank(S_BRANCH); e.alu_op = ALU_SUB; e.bsel = 1'b0;
                e.npc_sel = NPC_BRANCH; e.pc_wr = z;
                exp_q.push_back(e); rdy_q.push_back(noise());
            end
            K_J, K_JAL, K_JR: begin
                e = blank(S_JUMP); e.pc_wr = 1'b1;
                e.npc_sel = (inf.kind == K_JR) ? NPC_RS : NPC_JUMP;
                if (inf.kind == K_JAL) begin
                    e.gpr_wr = 1'b1; e.gpr_sel = GPR_RA; e.wd_sel = WD_PC4;
                end
                exp_q.push_back(e); rdy_q.push_back(noise());
            end
            default: begin
                for (int j = 0; j < 3; j++) begin
                    e = blank(S_TRAP); e.trap = 1'b1;
                    exp_q.push_back(e); rdy_q.push_back(noise());
                end
            end
        endcase
    endtask

    // Drive one instruction and compare every cycle against the model trace
    task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input int waits, input logic z, input logic ov, input int limit,
                       output bit trapped);
        int n;
        build(op, fn, waits, z, ov);
        n = (limit < exp_q.size()) ? limit : exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            opcode    = op;
            funct     = fn;
            zero      = z;
            of        = ov;
            mem_ready = rdy_q[k];
            @(negedge clk);
            check($sformatf("%s c%0d", nm, k), 32'(w_obs), 32'(exp_q[k]));
        end
        trapped = exp_q[n-1].trap;
    endtask

    // Assert reset now (mid-cycle), hold it, release on a falling edge
    task automatic reset_now();
        obs_t z0;
        z0 = blank(S_FETCH);
        rst = 1'b1;
        #1;
        check("rst_async", 32'(w_obs), 32'(z0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release", 32'(w_obs), 32'(z0));
    endtask

    task automatic reset_after_trap();
        @(posedge clk);
        #3;
        reset_now();
    endtask

    task automatic pick_legal(output logic [5:0] op, output logic [5:0] fn, output string nm);
        fn = 6'($urandom);
        case ($urandom_range(0, 12))
            0:  begin op = 6'h00; fn = 6'h21; nm = "addu"; end
            1:  begin op = 6'h00; fn = 6'h23; nm = "subu"; end
            2:  begin op = 6'h08; nm = "addi"; end
            3:  begin op = 6'h0D; nm = "ori";  end
            4:  begin op = 6'h0F; nm = "lui";  end
            5:  begin op = 6'h23; nm = "lw";   end
            6:  begin op = 6'h2B; nm = "sw";   end
            7:  begin op = 6'h20; nm = "lb";   end
            8:  begin op = 6'h28; nm = "sb";   end
            9:  begin op = 6'h04; nm = "beq";  end
            10: begin op = 6'h02; nm = "j";    end
            11: begin op = 6'h03; nm = "jal";  end
            default: begin op = 6'h00; fn = 6'h08; nm = "jr"; end
        endcase
    endtask

    initial begin
        bit         tr;
        logic [5:0] op, fn;
        string      nm;
        obs_t       z0;
        int         waits;

        z0 = blank(S_FETCH);
        #12;
        check("reset_state", 32'(w_obs), 32'(z0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_no_pulse", 32'(w_obs), 32'(z0));

        // R-type and immediate ALU paths
        run("addu", 6'h00, 6'h21, 0, 1'b0, 1'b0, 99, tr);
        run("subu", 6'h00, 6'h23, 0, 1'b1, 1'b1, 99, tr);
        run("ori",  6'h0D, 6'h15, 0, 1'b0, 1'b0, 99, tr);
        run("lui",  6'h0F, 6'h00, 0, 1'b0, 1'b0, 99, tr);

        // Memory paths with waits below the timeout
        run("lw_w3", 6'h23, 6'h00, 3, 1'b0, 1'b0, 99, tr);
        run("lw_w0", 6'h23, 6'h00, 0, 1'b0, 1'b0, 99, tr);
        run("sw_w0", 6'h2B, 6'h00, 0, 1'b0, 1'b0, 99, tr);
        run("lb_w2", 6'h20, 6'h00, 2, 1'b0, 1'b0, 99, tr);
        run("sb_w1", 6'h28, 6'h00, 1, 1'b0, 1'b0, 99, tr);

        // Branch taken / not taken, jumps
        run("beq_z1", 6'h04, 6'h00, 0, 1'b1, 1'b0, 99, tr);
        run("beq_z0", 6'h04, 6'h00, 0, 1'b0, 1'b0, 99, tr);
        run("jal", 6'h03, 6'h00, 0, 1'b0, 1'b0, 99, tr);
        run("j",   6'h02, 6'h00, 0, 1'b0, 1'b0, 99, tr);
        run("jr",  6'h00, 6'h08, 0, 1'b0, 1'b0, 99, tr);

        // addi with and without overflow, then an illegal opcode
        run("addi_of1", 6'h08, 6'h00, 0, 1'b0, 1'b1, 99, tr);
        run("addi_of0", 6'h08, 6'h00, 0, 1'b0, 1'b0, 99, tr);
        run("ill_3f", 6'h3F, 6'h00, 0, 1'b0, 1'b0, 99, tr);
        check("ill_trapped", 32'(o_trap), 32'(1));
        reset_after_trap();

        // Store that never completes: TRAP after TO waits
        run("sw_timeout", 6'h2B, 6'h00, 1000, 1'b0, 1'b0, 99, tr);
        reset_after_trap();

        // Reset during a memory wait drops mem_req at once
        run("sw_abort", 6'h2B, 6'h00, 1000, 1'b0, 1'b0, 5, tr);
        @(posedge clk);
        #2;
        check("mem_req_before_rst", 32'(o_mem_req), 32'(1));
        #1;
        reset_now();

        // Byte ops are illegal on the instance built without byte support
        check("nobyte_trap_clear", 32'(b_trap), 32'(0));
        run("lb_byte_cfg", 6'h20, 6'h00, 0, 1'b0, 1'b0, 99, tr);
        check("nobyte_lb_trap", 32'(b_trap), 32'(1));
        check("nobyte_state", 32'(b_state), 32'(S_TRAP));
        check("nobyte_no_req", 32'(b_mem_req), 32'(0));

        // Randomized instruction stream
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                do begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                end while (classify(op, fn, 1'b1).kind != K_ILL);
                nm = "rnd_ill";
            end else begin
                pick_legal(op, fn, nm);
            end
            waits = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 2))
                                                : int'($urandom_range(0, TO - 1));
            run($sformatf("rnd%0d_%s", i, nm), op, fn, waits,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 99, tr);
            if (tr) reset_after_trap();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
